// File: rtl/dbg_mem_ctl_pkg.sv
// Shared definitions for the debug memory controller: register map,
// MEM_CTL bit positions and the controller state encoding.
package dbg_mem_ctl_pkg;

    localparam logic [5:0] ADDR_MEM_CTL  = 6'h08;
    localparam logic [5:0] ADDR_MEM_ADDR = 6'h09;
    localparam logic [5:0] ADDR_MEM_DATA = 6'h0A;
    localparam logic [5:0] ADDR_MEM_CNT  = 6'h0B;

    localparam int CTL_START = 0;
    localparam int CTL_WR    = 1;
    localparam int CTL_BW    = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SINGLE     = 2'd1,
        BURST_WAIT = 2'd2,
        BURST_ACC  = 2'd3
    } state_t;

endpackage

// File: rtl/dbg_mem_ctl.sv
// Debug-port memory controller. A small register file (MEM_CTL, MEM_ADDR,
// MEM_DATA, MEM_CNT) drives single memory accesses and, when the
// DBG_MEM_BURST_EN macro is defined, counted bursts. Without the macro
// MEM_CNT is held at zero and every START performs a single access.
module dbg_mem_ctl
    import dbg_mem_ctl_pkg::*;
(
    input  logic        mclk,
    input  logic        por,
    input  logic [5:0]  dbg_addr,
    input  logic [15:0] dbg_din,
    input  logic        dbg_wr,
    input  logic        dbg_rd,
    output logic [15:0] dbg_dout,
    output logic        dbg_rd_rdy,
    output logic        mem_burst,
    output logic        mem_burst_wr,
    output logic        mem_burst_rd,
    output logic        mem_burst_end,
    output logic        mem_bw,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    state_t      state;
    state_t      state_nxt;
    logic        ctl_wr;
    logic        ctl_bw;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [15:0] cnt_q;
    logic [15:0] step;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        start;

    assign start = dbg_wr && (dbg_addr == ADDR_MEM_CTL) && dbg_din[CTL_START];
    assign step  = ctl_bw ? 16'd1 : 16'd2;

    // Memory-side view is a continuous reflection of the register file.
    assign mem_req   = (state == SINGLE) || (state == BURST_ACC);
    assign mem_we    = mem_req && ctl_wr;
    assign mem_addr  = addr_q;
    assign mem_bw    = ctl_bw;
    assign mem_wdata = ctl_bw ? {8'h00, data_q[7:0]} : data_q;

    // State register.
    always_ff @(posedge mclk) begin
        if (por) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A START with a nonzero count opens a burst; write
    // bursts wait for data first, read bursts fire their first read at once.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cnt_q != 16'd0) begin
                        state_nxt = dbg_din[CTL_WR] ? BURST_WAIT : BURST_ACC;
                    end else begin
                        state_nxt = SINGLE;
                    end
                end
            end
            SINGLE: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            BURST_WAIT: begin
                if (ctl_wr ? dbg_wr : dbg_rd) begin
                    state_nxt = BURST_ACC;
                end
            end
            BURST_ACC: begin
                if (mem_ack) begin
                    state_nxt = (cnt_q == 16'd1) ? IDLE : BURST_WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register read mux; only the four mapped addresses answer.
    always_comb begin
        rd_data = 16'h0000;
        rd_hit  = 1'b1;
        case (dbg_addr)
            ADDR_MEM_CTL:  rd_data = {12'h000, ctl_bw, 1'b0, ctl_wr, 1'b0};
            ADDR_MEM_ADDR: rd_data = addr_q;
            ADDR_MEM_DATA: rd_data = data_q;
            ADDR_MEM_CNT:  rd_data = cnt_q;
            default:       rd_hit  = 1'b0;
        endcase
    end

    // Control, address and data registers. Debug writes land only in IDLE;
    // during an access they are dropped, except burst data in BURST_WAIT.
    always_ff @(posedge mclk) begin
        if (por) begin
            ctl_wr <= 1'b0;
            ctl_bw <= 1'b0;
            addr_q <= 16'h0000;
            data_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_wr) begin
                        case (dbg_addr)
                            ADDR_MEM_CTL: begin
                                ctl_wr <= dbg_din[CTL_WR];
                                ctl_bw <= dbg_din[CTL_BW];
                            end
                            ADDR_MEM_ADDR: addr_q <= dbg_din;
                            ADDR_MEM_DATA: data_q <= dbg_din;
                            default: ;
                        endcase
                    end
                end
                SINGLE: begin
                    if (mem_ack && !ctl_wr) begin
                        data_q <= mem_rdata;
                    end
                end
                BURST_WAIT: begin
                    if (ctl_wr && dbg_wr) begin
                        data_q <= dbg_din;
                    end
                end
                BURST_ACC: begin
                    if (mem_ack) begin
                        addr_q <= addr_q + step;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-data return: register reads in IDLE, memory data on burst reads.
    always_ff @(posedge mclk) begin
        if (por) begin
            dbg_dout   <= 16'h0000;
            dbg_rd_rdy <= 1'b0;
        end else begin
            dbg_rd_rdy <= 1'b0;
            if ((state == IDLE) && dbg_rd && rd_hit) begin
                dbg_rd_rdy <= 1'b1;
                dbg_dout   <= rd_data;
            end else if ((state == BURST_ACC) && mem_ack && !ctl_wr) begin
                dbg_rd_rdy <= 1'b1;
                dbg_dout   <= mem_rdata;
            end
        end
    end

`ifdef DBG_MEM_BURST_EN
    logic burst_wr_q;
    logic burst_rd_q;

    // Burst word counter: loaded from the debug port, counts down per ack.
    always_ff @(posedge mclk) begin
        if (por) begin
            cnt_q <= 16'h0000;
        end else if ((state == IDLE) && dbg_wr && (dbg_addr == ADDR_MEM_CNT)) begin
            cnt_q <= dbg_din;
        end else if ((state == BURST_ACC) && mem_ack) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    // One-cycle burst-start pulses, aligned with the first burst cycle.
    always_ff @(posedge mclk) begin
        if (por) begin
            burst_wr_q <= 1'b0;
            burst_rd_q <= 1'b0;
        end else begin
            burst_wr_q <= (state == IDLE) && (state_nxt == BURST_WAIT);
            burst_rd_q <= (state == IDLE) && (state_nxt == BURST_ACC);
        end
    end

    assign mem_burst     = (state == BURST_WAIT) || (state == BURST_ACC);
    assign mem_burst_wr  = burst_wr_q;
    assign mem_burst_rd  = burst_rd_q;
    assign mem_burst_end = mem_burst && (cnt_q == 16'd1);
`else
    assign cnt_q         = 16'h0000;
    assign mem_burst     = 1'b0;
    assign mem_burst_wr  = 1'b0;
    assign mem_burst_rd  = 1'b0;
    assign mem_burst_end = 1'b0;
`endif

endmodule
